// File: rtl/sync_data_deserializer_if.sv
// Output word stream of the data deserializer.
// Valid/ready handshake carrying one WORD_W-bit word per transfer.
interface sync_data_deserializer_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sync_data_deserializer.sv
// Mid-bit sampler packing comparator bits MSB-first into words,
// buffered in a small FIFO drained over a valid/ready interface.
module sync_data_deserializer #(
  parameter int DATARATE_DIV = 100,
  parameter int FRAME_BITS   = 1000,
  parameter int WORD_W       = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clki,
  input  logic rst_n,
  input  logic data_clk_enb,
  input  logic comp_out,
  sync_data_deserializer_if.master bus,
  output logic frame_active,
  output logic frame_done,
  output logic partial,
  output logic overflow,
  output logic [9:0] bit_count
);

  localparam int HALF = DATARATE_DIV / 2;
  localparam int TW   = $clog2(DATARATE_DIV);
  localparam int WBW  = $clog2(WORD_W) + 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              sync1;
  logic              sync2;
  logic              en_q;
  logic [TW-1:0]     tick_cnt;
  logic [WBW-1:0]    wbit;
  logic [WORD_W-2:0] shift_reg;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic start;
  logic stop;
  logic smp;
  logic push;
  logic pop;
  logic full;
  logic push_ok;

  assign start = data_clk_enb & ~en_q;
  assign stop  = ~data_clk_enb & en_q;

  assign smp = (state_q == RUN)
             && (tick_cnt == TW'(HALF - 1))
             && (bit_count != 10'(FRAME_BITS));

  assign push    = smp && (wbit == WBW'(WORD_W - 1));
  assign pop     = bus.out_valid & bus.out_ready;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign push_ok = push & (~full | pop);

  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign frame_active  = (state_q == RUN);
  assign frame_done    = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (bit_count == 10'(FRAME_BITS) || stop)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clki) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clki) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      en_q      <= 1'b0;
      tick_cnt  <= '0;
      wbit      <= '0;
      shift_reg <= '0;
      bit_count <= '0;
      partial   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sync1 <= comp_out;
      sync2 <= sync1;
      en_q  <= data_clk_enb;
      if (state_q == IDLE && start) begin
        tick_cnt  <= '0;
        wbit      <= '0;
        shift_reg <= '0;
        bit_count <= '0;
        partial   <= 1'b0;
        overflow  <= 1'b0;
      end else if (state_q == RUN) begin
        if (tick_cnt == TW'(DATARATE_DIV - 1))
          tick_cnt <= '0;
        else
          tick_cnt <= tick_cnt + TW'(1);
        if (smp) begin
          shift_reg <= {shift_reg[WORD_W-3:0], sync2};
          bit_count <= bit_count + 10'd1;
          wbit      <= push ? '0 : wbit + WBW'(1);
        end
      end else if (state_q == DONE && wbit != '0) begin
        // leftover bits of an unfinished word are dropped, not padded
        partial <= 1'b1;
        wbit    <= '0;
      end
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clki) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {shift_reg, sync2};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_sync_data_deserializer.sv
// Directed bench for the data deserializer.
// Short bit period keeps a full 1000-bit frame fast.
module tb_sync_data_deserializer;

  localparam int DIV = 4;
  localparam int FB  = 1000;
  localparam int W   = 8;
  localparam int D   = 4;

  logic       clki = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_clk_enb = 1'b0;
  logic       comp_out = 1'b0;
  logic       frame_active;
  logic       frame_done;
  logic       partial;
  logic       overflow;
  logic [9:0] bit_count;

  sync_data_deserializer_if #(.WORD_W(W)) bus ();

  sync_data_deserializer #(
    .DATARATE_DIV(DIV),
    .FRAME_BITS  (FB),
    .WORD_W      (W),
    .FIFO_DEPTH  (D)
  ) dut (
    .clki        (clki),
    .rst_n       (rst_n),
    .data_clk_enb(data_clk_enb),
    .comp_out    (comp_out),
    .bus         (bus),
    .frame_active(frame_active),
    .frame_done  (frame_done),
    .partial     (partial),
    .overflow    (overflow),
    .bit_count   (bit_count)
  );

  always #5 clki = ~clki;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  logic [7:0] got[$];

  always @(negedge clki) begin
    if (bus.out_valid && bus.out_ready)
      got.push_back(bus.out_data);
    if (frame_done)
      done_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clki);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int nb);
    for (int i = 0; i < nb; i++) begin
      comp_out = b[7-i];
      step(DIV);
    end
  endtask

  task automatic check_got(input string tag,
                           input logic [7:0] exp[$]);
    int bad;
    bad = 0;
    check({tag, "_n"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (got[i] !== exp[i]) bad++;
    check({tag, "_ord"}, bad, 0);
  endtask

  logic [7:0] pa;
  logic [7:0] exp_q[$];
  int d0;
  int bad;

  initial begin
    bus.out_ready = 1'b0;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      comp_out = ~comp_out;
      step(1);
    end
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_active", frame_active, 0);
    check("rst_done", frame_done, 0);
    check("rst_flags", {partial, overflow}, 0);
    check("rst_bc", bit_count, 0);
    rst_n = 1'b1;
    comp_out = 1'b0;
    step(1);

    // full frame, consumer always ready
    got.delete();
    bus.out_ready = 1'b1;
    pa = 8'hA5;
    comp_out = pa[7];
    data_clk_enb = 1'b1;
    step(1);
    check("f_active", frame_active, 1);
    check("f_bc0", bit_count, 0);
    step(1);
    check("f_bc_pre", bit_count, 0);
    step(1);
    check("f_first_smp", bit_count, 1);
    step(1);
    for (int i = 1; i < 8; i++) begin
      comp_out = pa[7-i];
      step(DIV);
    end
    for (int w = 1; w < 125; w++)
      send(pa, 8);
    check("f_done", frame_done, 1);
    check("f_bc", bit_count, 1000);
    step(1);
    check("f_done_pulse", frame_done, 0);
    check("f_partial", partial, 0);
    check("f_idle", frame_active, 0);
    step(3);
    check("f_words", got.size(), 125);
    bad = 0;
    foreach (got[i]) if (got[i] !== 8'hA5) bad++;
    check("f_word_val", bad, 0);
    data_clk_enb = 1'b0;
    step(2);

    // enable drops after 12 bits
    got.delete();
    data_clk_enb = 1'b1;
    send(8'h3C, 8);
    send(8'h3C, 4);
    data_clk_enb = 1'b0;
    step(1);
    check("s_done", frame_done, 1);
    step(1);
    check("s_done_pulse", frame_done, 0);
    check("s_partial", partial, 1);
    check("s_bc", bit_count, 12);
    exp_q = '{8'h3C};
    check_got("s_got", exp_q);

    // consumer stalled: FIFO fills then overflows
    bus.out_ready = 1'b0;
    got.delete();
    data_clk_enb = 1'b1;
    send(8'h11, 8);
    check("o_partial_clr", partial, 0);
    check("o_head", bus.out_data, 8'h11);
    send(8'h22, 8);
    send(8'h33, 8);
    send(8'h44, 8);
    check("o_no_ovf", overflow, 0);
    send(8'h55, 8);
    check("o_ovf", overflow, 1);
    check("o_head_hold", bus.out_data, 8'h11);
    check("o_valid", bus.out_valid, 1);
    data_clk_enb = 1'b0;
    step(2);
    check("o_partial", partial, 0);
    bus.out_ready = 1'b1;
    step(6);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_got("o_drain", exp_q);
    check("o_empty", bus.out_valid, 0);

    // push and pop together while full
    bus.out_ready = 1'b0;
    got.delete();
    data_clk_enb = 1'b1;
    send(8'hA1, 8);
    send(8'hB2, 8);
    send(8'hC3, 8);
    send(8'hD4, 8);
    send(8'hE5, 7);
    comp_out = 1'b1;
    step(2);
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    step(1);
    check("pp_no_ovf", overflow, 0);
    check("pp_head", bus.out_data, 8'hB2);
    check("pp_popped", got.size(), 1);
    data_clk_enb = 1'b0;
    step(2);
    bus.out_ready = 1'b1;
    step(8);
    exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    check_got("pp_drain", exp_q);

    // reset in the middle of a frame
    bus.out_ready = 1'b0;
    got.delete();
    data_clk_enb = 1'b1;
    for (int w = 0; w < 37; w++)
      send(8'h3C, 8);
    send(8'h3C, 4);
    check("r_bc300", bit_count, 300);
    check("r_ovf", overflow, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    data_clk_enb = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
    check("r_active", frame_active, 0);
    check("r_empty", bus.out_valid, 0);
    check("r_ovf_clr", overflow, 0);
    check("r_bc", bit_count, 0);
    check("r_no_done", done_cnt, d0);
    bus.out_ready = 1'b1;
    data_clk_enb = 1'b1;
    send(8'h5A, 8);
    check("r_new_active", frame_active, 1);
    check("r_new_bc", bit_count, 8);
    step(2);
    exp_q = '{8'h5A};
    check_got("r_new", exp_q);
    data_clk_enb = 1'b0;
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
